// File: rtl/pdm_interp.sv
// Linear interpolator feeding the sigma-delta PDM modulator: upsamples 16-bit audio by 2^LOG2R
// and emits one interpolated value per oversample strobe.
module pdm_interp #(
   parameter int DIV   = 8,
   parameter int LOG2R = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               run,
   input  logic signed [15:0] in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic signed [15:0] pdm_in,
   output logic               pdm_ena,
   output logic               underrun
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int ACC_W = 17 + LOG2R;

   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [LOG2R-1:0]        phase_q, phase_d;
   logic                    pend_valid_q, pend_valid_d;
   logic signed [15:0]      pend_data_q, pend_data_d;
   logic signed [15:0]      cur_q, cur_d;
   logic signed [16:0]      step_q, step_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [15:0]      pdm_in_q, pdm_in_d;
   logic                    pdm_ena_q;
   logic                    underrun_q, underrun_d;

   logic                    tick;
   logic                    boundary;
   logic                    accept;
   logic signed [ACC_W-1:0] acc_sum;
   logic signed [ACC_W-1:0] cur_scaled;

   // Arithmetic shift gives floor division by R; the result always lies between two samples.
   function automatic logic signed [15:0] floor_scale(input logic signed [ACC_W-1:0] a);
      return 16'(a >>> LOG2R);
   endfunction

   assign tick       = run && (cnt_q == CNT_W'(DIV - 1));
   assign boundary   = tick && (phase_q == {LOG2R{1'b1}});
   assign accept     = in_valid && !pend_valid_q;
   assign acc_sum    = acc_q + {{LOG2R{step_q[16]}}, step_q};
   assign cur_scaled = {{(LOG2R + 1){cur_q[15]}}, cur_q} << LOG2R;

   always_comb begin
      cnt_d        = run ? (tick ? '0 : cnt_q + 1'b1) : '0;
      phase_d      = phase_q;
      pend_valid_d = pend_valid_q;
      pend_data_d  = pend_data_q;
      cur_d        = cur_q;
      step_d       = step_q;
      acc_d        = acc_q;
      pdm_in_d     = pdm_in_q;
      underrun_d   = 1'b0;

      // Ready is low while the entry is full, so accept and consume never overlap.
      if (accept) begin
         pend_valid_d = 1'b1;
         pend_data_d  = in_data;
      end

      if (tick) begin
         phase_d = phase_q + 1'b1;
         if (boundary) begin
            acc_d    = cur_scaled;
            pdm_in_d = cur_q;
            if (pend_valid_q) begin
               step_d       = {pend_data_q[15], pend_data_q} - {cur_q[15], cur_q};
               cur_d        = pend_data_q;
               pend_valid_d = 1'b0;
            end else begin
               step_d     = '0;
               underrun_d = 1'b1;
            end
         end else begin
            acc_d    = acc_sum;
            pdm_in_d = floor_scale(acc_sum);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q        <= '0;
         phase_q      <= '0;
         pend_valid_q <= 1'b0;
         pend_data_q  <= '0;
         cur_q        <= '0;
         step_q       <= '0;
         acc_q        <= '0;
         pdm_in_q     <= '0;
         pdm_ena_q    <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         phase_q      <= phase_d;
         pend_valid_q <= pend_valid_d;
         pend_data_q  <= pend_data_d;
         cur_q        <= cur_d;
         step_q       <= step_d;
         acc_q        <= acc_d;
         pdm_in_q     <= pdm_in_d;
         pdm_ena_q    <= tick;
         underrun_q   <= underrun_d;
      end
   end

   assign in_ready = !pend_valid_q;
   assign pdm_in   = pdm_in_q;
   assign pdm_ena  = pdm_ena_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_pdm_interp.sv
// Scoreboard bench for pdm_interp: a segment-level reference model predicts every strobe value,
// and a monitor compares each presented strobe against it.
module tb_pdm_interp;

   localparam int DIV_T   = 4;
   localparam int LOG2R_T = 2;
   localparam int R       = 1 << LOG2R_T;

   logic               clk;
   logic               reset_n;
   logic               run;
   logic signed [15:0] in_data;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] pdm_in;
   logic               pdm_ena;
   logic               underrun;

   pdm_interp #(.DIV(DIV_T), .LOG2R(LOG2R_T)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .run     (run),
      .in_data (in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .pdm_in  (pdm_in),
      .pdm_ena (pdm_ena),
      .underrun(underrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int val;
      bit und;
   } exp_t;

   exp_t exp_q[$];
   int   obs[$];
   int   ref_vals[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   // Reference model state: a segment runs from seg_a to seg_b over R ticks.
   int m_cnt, m_phase, m_pdata, seg_a, seg_b;
   bit m_pend;
   int last_val;

   task automatic chk(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic int floor_div(input int num, input int den);
      int q;
      q = num / den;
      if ((num % den != 0) && (num < 0)) q = q - 1;
      return q;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_cnt = 0; m_phase = 0; m_pend = 0; m_pdata = 0; seg_a = 0; seg_b = 0;
         exp_q.delete();
      end else begin
         bit   tick, accept;
         exp_t e;
         tick   = run && (m_cnt == DIV_T - 1);
         accept = in_valid && !m_pend;
         m_cnt  = (run && !tick) ? m_cnt + 1 : 0;
         if (tick) begin
            if (m_phase == R - 1) begin
               e.val = seg_b;
               e.und = !m_pend;
               seg_a = seg_b;
               if (m_pend) begin
                  seg_b  = m_pdata;
                  m_pend = 0;
               end
               m_phase = 0;
            end else begin
               e.val   = seg_a + floor_div((m_phase + 1) * (seg_b - seg_a), R);
               e.und   = 0;
               m_phase = m_phase + 1;
            end
            exp_q.push_back(e);
         end
         if (accept) begin
            m_pend  = 1;
            m_pdata = int'(in_data);
         end
      end
   end

   always @(negedge clk) begin
      if (!reset_n) begin
         chk("rst_pdm_in", int'(pdm_in), 0);
         chk("rst_pdm_ena", int'(pdm_ena), 0);
         chk("rst_underrun", int'(underrun), 0);
         chk("rst_in_ready", int'(in_ready), 1);
         last_val = 0;
      end else begin
         chk("in_ready", int'(in_ready), int'(!m_pend));
         if (pdm_ena) begin
            if (exp_q.size() == 0) begin
               chk("spurious_ena", int'(pdm_ena), 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("pdm_in", int'(pdm_in), e.val);
               chk("underrun", int'(underrun), int'(e.und));
               last_val = e.val;
            end
            obs.push_back(int'(pdm_in));
         end else begin
            chk("underrun_idle", int'(underrun), 0);
            chk("pdm_in_hold", int'(pdm_in), last_val);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      #1 reset_n = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("async_pdm_in", int'(pdm_in), 0);
      chk("async_pdm_ena", int'(pdm_ena), 0);
      chk("async_in_ready", int'(in_ready), 1);
      repeat (2) @(negedge clk);
      obs.delete();
      #1 reset_n = 1'b1;
   endtask

   task automatic send(input int v);
      int b;
      b = 0;
      while (!in_ready && b < 200) begin
         @(negedge clk);
         b++;
      end
      chk("send_ready", int'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = 16'(v);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic check_obs(input string name);
      int b;
      b = 0;
      while (obs.size() < ref_vals.size() && b < 400) begin
         @(negedge clk);
         b++;
      end
      chk({name, "_count"}, (obs.size() >= ref_vals.size()) ? 1 : 0, 1);
      for (int i = 0; i < ref_vals.size() && i < obs.size(); i++)
         chk(name, obs[i], ref_vals[i]);
   endtask

   initial begin
      reset_n  = 1'b0;
      run      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;

      do_reset();
      send(400);
      ref_vals = '{0, 0, 0, 0, 100, 200, 300, 400};
      check_obs("seq_400");

      do_reset();
      send(400);
      send(-400);
      ref_vals = '{0, 0, 0, 0, 100, 200, 300, 400, 200, 0, -200, -400};
      check_obs("seq_pm400");

      do_reset();
      send(0);
      send(3);
      ref_vals = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3};
      check_obs("seq_round");

      do_reset();
      send(32767);
      send(-32768);
      ref_vals = '{0, 0, 0, 0, 8191, 16383, 24575, 32767, 16383, -1, -16385, -32768};
      check_obs("seq_fullscale");

      // Continuous valid with changing data, then random traffic with run gaps.
      do_reset();
      for (int c = 0; c < 2400; c++) begin
         @(negedge clk);
         in_data  = 16'($urandom);
         in_valid = (c < 400) ? 1'b1 : ($urandom_range(0, 3) != 0);
         run      = !(c >= 702 && c < 712) && ((c < 400) || ($urandom_range(0, 49) != 0));
         if (c == 1500) begin
            run = 1'b1;
            do_reset();
         end
      end
      in_valid = 1'b0;
      run      = 1'b1;
      repeat (20) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
